mem_refill_arbiter: RTL and testbench

// Shares the single backing-memory refill port among NUM_REQ cache controllers
// (e.g. I-cache and D-cache miss FSMs). Each controller raises a line-refill

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_refill_arbiter_if.sv | 30 +++
 rtl/mem_refill_arbiter_rr.sv | 34 +++
 rtl/mem_refill_arbiter.sv | 104 ++++++++++
 tb/tb_mem_refill_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory refill arbiter and the cache
// controllers that talk to it.
package mem_arb_pkg;

  localparam int ADDR_W = 8;    // line address {tag[27:22], lineid}
  localparam int LINE_W = 128;  // one refill line, 4 x 32-bit words

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

endpackage : mem_arb_pkg

// File: rtl/mem_refill_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the refill arbiter.
// master: the arbiter itself. slave: the requesters plus backing memory.
interface mem_refill_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
  parameter int LINE_W  = mem_arb_pkg::LINE_W
);

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        done_o;
  logic [LINE_W-1:0]         rdata_o;
  logic                      mem_req_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic [LINE_W-1:0]         mem_data_i;
  logic                      mem_comp_i;
  logic                      busy_o;

  modport master (
    input  req_i, req_addr_i, mem_data_i, mem_comp_i,
    output gnt_o, done_o, rdata_o, mem_req_o, mem_addr_o, busy_o
  );

  modport slave (
    output req_i, req_addr_i, mem_data_i, mem_comp_i,
    input  gnt_o, done_o, rdata_o, mem_req_o, mem_addr_o, busy_o
  );

endinterface : mem_refill_arbiter_if

// File: rtl/mem_refill_arbiter_rr.sv
// Combinational round-robin picker: the winner is the first set request bit
// found when searching upward from ptr+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Scan candidates ptr+1 .. ptr+NUM_REQ; the first requesting one wins.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the tool infers a latch to hold it.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/mem_refill_arbiter.sv
// Shares one backing-memory refill port among NUM_REQ cache controllers.
// One transaction at a time: IDLE picks a winner round-robin, ISSUE holds
// mem_req until mem_comp, RESP pulses done with the captured line.
module mem_refill_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
  parameter int LINE_W  = mem_arb_pkg::LINE_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_refill_arbiter_if.master  bus
);

  import mem_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   win_id_q;
  logic [NUM_REQ-1:0] win_oh_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  data_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (bus.req_i),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state selection and per-state output decode.
  always_comb begin
    state_d       = state_q;
    bus.mem_req_o = 1'b0;
    bus.gnt_o     = '0;
    bus.done_o    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) state_d = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        bus.mem_req_o = 1'b1;
        bus.gnt_o     = win_oh_q;
        if (bus.mem_comp_i) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        bus.gnt_o  = win_oh_q;
        bus.done_o = win_oh_q;
        state_d    = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register; a reset mid-transaction simply abandons it.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // Transaction registers: winner and address latched on grant, line
  // captured on completion, rotation pointer advanced as the done pulse goes out.
  // NOTE: these are a handful of flops, not a memory array, so all of them
  // are reset; outputs therefore read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_id_q <= '0;
      win_oh_q <= '0;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            win_id_q <= pick_idx;
            win_oh_q <= pick_gnt;
            addr_q   <= bus.req_addr_i[pick_idx*ADDR_W +: ADDR_W];
          end
        end
        ARB_ISSUE: begin
          if (bus.mem_comp_i) data_q <= bus.mem_data_i;
        end
        ARB_RESP: begin
          rr_ptr_q <= win_id_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr_o = addr_q;
  assign bus.rdata_o    = data_q;
  assign bus.busy_o     = (state_q != ARB_IDLE);

endmodule : mem_refill_arbiter

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin model.
module tb_mem_refill_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int LW = 128;

  logic clk;
  logic reset_n;

  int total;
  int bad;

  int           model_ptr;    // index of the last requester served
  logic [LW-1:0] model_rdata; // line the DUT should be presenting on rdata_o

  mem_refill_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_refill_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner: first requesting index after the last served one, wrapping.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    model_ptr   = N - 1;
    model_rdata = '0;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr_i[i*AW +: AW] = a;
  endtask

  // Drives one transaction from IDLE to IDLE and reports what was observed.
  // Completion is signalled on the n_issue-th cycle of mem_req_o.
  task automatic run_txn(input int n_issue, input logic [LW-1:0] data,
                         output logic [N-1:0] gnt_seen, output logic [AW-1:0] addr_seen,
                         output int mreq_cycles, output logic [N-1:0] done_seen,
                         output logic [LW-1:0] rdata_seen, output logic [N-1:0] done_after,
                         output logic mreq_resp);
    int guard;
    guard = 0;
    mreq_cycles = 0;
    step();
    gnt_seen  = bus.gnt_o;
    addr_seen = bus.mem_addr_o;
    while (bus.mem_req_o === 1'b1 && guard < 1000) begin
      mreq_cycles++;
      guard++;
      if (mreq_cycles == n_issue) begin
        bus.mem_comp_i = 1'b1;
        bus.mem_data_i = data;
      end
      step();
      bus.mem_comp_i = 1'b0;
      bus.mem_data_i = rand_line();
    end
    done_seen  = bus.done_o;
    rdata_seen = bus.rdata_o;
    mreq_resp  = bus.mem_req_o;
    bus.req_i  = bus.req_i & ~done_seen;
    step();
    done_after = bus.done_o;
  endtask

  task automatic test_reset();
    bus.req_i      = '0;
    bus.req_addr_i = '0;
    bus.mem_comp_i = 1'b0;
    bus.mem_data_i = '0;
    reset_n = 1'b0;
    step();
    step();
    total++; if (bus.gnt_o !== '0) begin bad++; $display("FAIL reset_gnt: got %b expected 0", bus.gnt_o); end
    total++; if (bus.done_o !== '0) begin bad++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req_o); end
    total++; if (bus.mem_addr_o !== '0) begin bad++; $display("FAIL reset_mem_addr: got %h expected 00", bus.mem_addr_o); end
    total++; if (bus.rdata_o !== '0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    reset_n = 1'b1;
    model_ptr   = N - 1;
    model_rdata = '0;
  endtask

  task automatic test_single();
    logic [N-1:0] g, d, da; logic [AW-1:0] a; logic [LW-1:0] r, data; int mc; logic mr;
    data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
    bus.req_i = 2'b01;
    set_addr(0, 8'h3A);
    run_txn(4, data, g, a, mc, d, r, da, mr);
    total++; if (g !== 2'b01) begin bad++; $display("FAIL single_gnt: got %b expected 01", g); end
    total++; if (a !== 8'h3A) begin bad++; $display("FAIL single_addr: got %h expected 3a", a); end
    total++; if (mc !== 4) begin bad++; $display("FAIL single_mem_req_len: got %0d expected 4", mc); end
    total++; if (d !== 2'b01) begin bad++; $display("FAIL single_done: got %b expected 01", d); end
    total++; if (r !== data) begin bad++; $display("FAIL single_rdata: got %h expected %h", r, data); end
    total++; if (da !== 2'b00) begin bad++; $display("FAIL single_done_width: got %b expected 00", da); end
    total++; if (mr !== 1'b0) begin bad++; $display("FAIL single_mem_req_in_resp: got %b expected 0", mr); end
    model_ptr   = 0;
    model_rdata = data;
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] g, d, da, exp_oh; logic [AW-1:0] a, exp_a; logic [LW-1:0] r, data;
    int mc, exp; logic mr;
    do_reset();
    set_addr(0, 8'h10);
    set_addr(1, 8'h20);
    bus.req_i = 2'b11;
    for (int t = 0; t < 3; t++) begin
      // Second round re-raises requester 0 while requester 1 is still waiting.
      if (t == 1) bus.req_i = bus.req_i | 2'b01;
      exp    = model_pick(bus.req_i, model_ptr);
      exp_oh = N'(1) << exp;
      exp_a  = (exp == 0) ? 8'h10 : 8'h20;
      data   = rand_line();
      run_txn(2, data, g, a, mc, d, r, da, mr);
      total++; if (g !== exp_oh) begin bad++; $display("FAIL simul_gnt[%0d]: got %b expected %b", t, g, exp_oh); end
      total++; if (a !== exp_a) begin bad++; $display("FAIL simul_addr[%0d]: got %h expected %h", t, a, exp_a); end
      total++; if (d !== exp_oh) begin bad++; $display("FAIL simul_done[%0d]: got %b expected %b", t, d, exp_oh); end
      model_ptr   = exp;
      model_rdata = data;
    end
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] exp_oh; logic [LW-1:0] data; int exp, err;
    bus.req_i = 2'b10;
    set_addr(1, 8'hB7);
    exp    = model_pick(bus.req_i, model_ptr);
    exp_oh = N'(1) << exp;
    step();
    err = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.mem_req_o !== 1'b1 || bus.gnt_o !== exp_oh || bus.done_o !== '0) err++;
      step();
    end
    total++; if (err !== 0) begin bad++; $display("FAIL bp_hold: got %0d bad cycles expected 0", err); end
    total++; if (bus.mem_addr_o !== 8'hB7) begin bad++; $display("FAIL bp_addr: got %h expected b7", bus.mem_addr_o); end
    data = rand_line();
    bus.mem_comp_i = 1'b1;
    bus.mem_data_i = data;
    step();
    bus.mem_comp_i = 1'b0;
    total++; if (bus.done_o !== exp_oh) begin bad++; $display("FAIL bp_done: got %b expected %b", bus.done_o, exp_oh); end
    total++; if (bus.rdata_o !== data) begin bad++; $display("FAIL bp_rdata: got %h expected %h", bus.rdata_o, data); end
    bus.req_i = bus.req_i & ~exp_oh;
    step();
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL bp_idle: got %b expected 0", bus.busy_o); end
    model_ptr   = exp;
    model_rdata = data;
  endtask

  task automatic test_change_during_issue();
    logic [N-1:0] exp_oh, nxt_oh; logic [LW-1:0] data; int exp, nxt, err;
    bus.req_i = 2'b01;
    set_addr(0, 8'h44);
    exp    = model_pick(bus.req_i, model_ptr);
    exp_oh = N'(1) << exp;
    step();
    step();
    bus.req_i = 2'b11;
    set_addr(0, 8'hFF);
    set_addr(1, 8'h77);
    err = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.mem_addr_o !== 8'h44 || bus.gnt_o !== exp_oh || bus.mem_req_o !== 1'b1) err++;
    end
    total++; if (err !== 0) begin bad++; $display("FAIL chg_latched: got %0d bad cycles expected 0", err); end
    data = rand_line();
    bus.mem_comp_i = 1'b1;
    bus.mem_data_i = data;
    step();
    bus.mem_comp_i = 1'b0;
    total++; if (bus.done_o !== exp_oh) begin bad++; $display("FAIL chg_done: got %b expected %b", bus.done_o, exp_oh); end
    total++; if (bus.gnt_o !== exp_oh) begin bad++; $display("FAIL chg_gnt_resp: got %b expected %b", bus.gnt_o, exp_oh); end
    total++; if (bus.rdata_o !== data) begin bad++; $display("FAIL chg_rdata: got %h expected %h", bus.rdata_o, data); end
    model_ptr   = exp;
    model_rdata = data;
    bus.req_i = bus.req_i & ~exp_oh;
    step();
    total++; if (bus.gnt_o !== '0) begin bad++; $display("FAIL chg_gnt_idle: got %b expected 00", bus.gnt_o); end
    nxt    = model_pick(bus.req_i, model_ptr);
    nxt_oh = N'(1) << nxt;
    step();
    total++; if (bus.gnt_o !== nxt_oh) begin bad++; $display("FAIL chg_next_gnt: got %b expected %b", bus.gnt_o, nxt_oh); end
    total++; if (bus.mem_addr_o !== 8'h77) begin bad++; $display("FAIL chg_next_addr: got %h expected 77", bus.mem_addr_o); end
    data = rand_line();
    bus.mem_comp_i = 1'b1;
    bus.mem_data_i = data;
    step();
    bus.mem_comp_i = 1'b0;
    total++; if (bus.done_o !== nxt_oh) begin bad++; $display("FAIL chg_next_done: got %b expected %b", bus.done_o, nxt_oh); end
    bus.req_i = bus.req_i & ~nxt_oh;
    step();
    model_ptr   = nxt;
    model_rdata = data;
  endtask

  task automatic test_reset_mid_issue();
    logic [N-1:0] g, d, da, exp_oh; logic [AW-1:0] a; logic [LW-1:0] r, data;
    int mc, exp; logic mr;
    bus.req_i = 2'b10;
    set_addr(1, 8'h55);
    step();
    total++; if (bus.mem_req_o !== 1'b1) begin bad++; $display("FAIL rst_mid_issue: got %b expected 1", bus.mem_req_o); end
    step();
    reset_n = 1'b0;
    step();
    reset_n   = 1'b1;
    bus.req_i = '0;
    model_ptr   = N - 1;
    model_rdata = '0;
    total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mid_mem_req: got %b expected 0", bus.mem_req_o); end
    total++; if (bus.gnt_o !== '0) begin bad++; $display("FAIL rst_mid_gnt: got %b expected 00", bus.gnt_o); end
    bus.mem_comp_i = 1'b1;
    bus.mem_data_i = rand_line();
    step();
    bus.mem_comp_i = 1'b0;
    total++; if (bus.done_o !== '0) begin bad++; $display("FAIL rst_mid_done: got %b expected 00", bus.done_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy_o); end
    total++; if (bus.rdata_o !== model_rdata) begin bad++; $display("FAIL rst_mid_rdata: got %h expected %h", bus.rdata_o, model_rdata); end
    set_addr(0, 8'h10);
    set_addr(1, 8'h20);
    bus.req_i = 2'b11;
    for (int t = 0; t < 2; t++) begin
      exp    = model_pick(bus.req_i, model_ptr);
      exp_oh = N'(1) << exp;
      data   = rand_line();
      run_txn(2, data, g, a, mc, d, r, da, mr);
      total++; if (g !== exp_oh) begin bad++; $display("FAIL rst_mid_prio[%0d]: got %b expected %b", t, g, exp_oh); end
      model_ptr   = exp;
      model_rdata = data;
    end
  endtask

  task automatic test_stray_comp();
    int err;
    bus.req_i = '0;
    step();
    err = 0;
    bus.mem_comp_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.mem_data_i = rand_line();
      step();
      if (bus.busy_o !== 1'b0 || bus.done_o !== '0 || bus.mem_req_o !== 1'b0) err++;
    end
    bus.mem_comp_i = 1'b0;
    total++; if (err !== 0) begin bad++; $display("FAIL stray_state: got %0d bad cycles expected 0", err); end
    total++; if (bus.rdata_o !== model_rdata) begin bad++; $display("FAIL stray_rdata: got %h expected %h", bus.rdata_o, model_rdata); end
  endtask

  task automatic test_random();
    logic [N-1:0] g, d, da, exp_oh; logic [AW-1:0] a; logic [LW-1:0] r, data;
    logic [AW-1:0] addrs [N];
    int waits [N];
    int mc, exp, n, worst; logic mr;
    worst = 0;
    for (int i = 0; i < N; i++) begin
      addrs[i] = '0;
      waits[i] = 0;
    end
    bus.req_i = '0;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_i[i] && $urandom_range(0, 2) != 0) begin
          bus.req_i[i] = 1'b1;
          addrs[i] = AW'($urandom);
          set_addr(i, addrs[i]);
        end
      end
      if (bus.req_i == '0) begin
        step();
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rnd_idle[%0d]: got %b expected 0", it, bus.busy_o); end
        continue;
      end
      exp    = model_pick(bus.req_i, model_ptr);
      exp_oh = N'(1) << exp;
      n      = $urandom_range(1, 5);
      data   = rand_line();
      for (int i = 0; i < N; i++) begin
        if (i == exp) waits[i] = 0;
        else if (bus.req_i[i]) begin
          waits[i]++;
          if (waits[i] > worst) worst = waits[i];
        end
      end
      run_txn(n, data, g, a, mc, d, r, da, mr);
      total++; if (g !== exp_oh) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", it, g, exp_oh); end
      total++; if (a !== addrs[exp]) begin bad++; $display("FAIL rnd_addr[%0d]: got %h expected %h", it, a, addrs[exp]); end
      total++; if (mc !== n) begin bad++; $display("FAIL rnd_mem_req_len[%0d]: got %0d expected %0d", it, mc, n); end
      total++; if (d !== exp_oh) begin bad++; $display("FAIL rnd_done[%0d]: got %b expected %b", it, d, exp_oh); end
      total++; if (r !== data) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", it, r, data); end
      total++; if (da !== '0) begin bad++; $display("FAIL rnd_done_width[%0d]: got %b expected 00", it, da); end
      model_ptr   = exp;
      model_rdata = data;
    end
    total++; if (worst > N - 1) begin bad++; $display("FAIL rnd_starvation: got wait %0d expected at most %0d", worst, N - 1); end
    bus.req_i = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_pressure();
    test_change_during_issue();
    test_reset_mid_issue();
    test_stray_comp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_refill_arbiter
